// File: rtl/key_debounce_if.sv
// key_debounce_if: signal bundle between a raw push-button and its debouncer.
// The slave side is the debouncer: it takes the raw active-low key and returns
// the clean level, the one-cycle press/release/long strobes and the FSM state
// for observation. The master side is whoever owns the physical key.
interface key_debounce_if;
    logic       key_n;        // raw key, asynchronous, 0 = pressed
    logic       key_level;    // debounced state, 1 = pressed
    logic       key_press;    // one-cycle pulse on an accepted press
    logic       key_release;  // one-cycle pulse on an accepted release
    logic       key_long;     // one-cycle pulse on a long press (0 without KEY_LONGPRESS_EN)
    logic [1:0] state_dbg;    // current debounce FSM state, for observation only

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  state_dbg
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output state_dbg
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: debounces one raw active-low push-button.
// The key is brought into the clk domain with a 2-FF synchronizer, then a
// four-state FSM (IDLE, PDEB, DOWN, RDEB) requires CNT_MAX consecutive stable
// samples before accepting a press or a release. All outputs are registered.
// Optional feature: define KEY_LONGPRESS_EN to add a long-press strobe that
// fires once per press, LONG_MAX cycles after key_press while held.
// Reset is synchronous, active-low; reset from any state returns silently to
// IDLE without a release pulse.
module key_debounce #(
    parameter int CNT_MAX  = 240000,
    parameter int CNT_W    = 18,
    parameter int LONG_MAX = 12000000,
    parameter int LONG_W   = 24
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave bus
);

    // Elaboration-time sanity checks on the parameter set.
    if (CNT_MAX < 2) begin : g_bad_cnt_max
        $error("key_debounce: CNT_MAX must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(CNT_MAX)) begin : g_bad_cnt_w
        $error("key_debounce: CNT_W too narrow for CNT_MAX");
    end
    if (LONG_MAX < 1) begin : g_bad_long_max
        $error("key_debounce: LONG_MAX must be at least 1");
    end
    if ((64'd1 << LONG_W) <= 64'(LONG_MAX)) begin : g_bad_long_w
        $error("key_debounce: LONG_W too narrow for LONG_MAX");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // released and stable
        PDEB = 2'd1,  // saw a press, waiting for it to stay stable
        DOWN = 2'd2,  // pressed and stable
        RDEB = 2'd3   // saw a release, waiting for it to stay stable
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    // Two-flop synchronizer; resets to "released" so reset never looks like a press edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= bus.key_n;
            r_s2 <= r_s1;
        end
    end

    // Next-state, counter and strobe decode; cnt clears on every state change.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
                if (!r_s2) begin
                    w_state_nxt = PDEB;
                end
            end
            PDEB: begin
                if (r_s2) begin
                    // Bounce: drop back without any output.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b1;
                if (r_s2) begin
                    w_state_nxt = RDEB;
                end
            end
            RDEB: begin
                if (!r_s2) begin
                    // Bounce while releasing: still held, no output.
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign bus.key_level   = r_level;
    assign bus.key_press   = r_press;
    assign bus.key_release = r_release;
    assign bus.state_dbg   = r_state;

`ifdef KEY_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);

    logic [LONG_W-1:0] r_lcnt;
    logic              r_lfired;
    logic              r_long;
    logic              w_enter_down;

    assign w_enter_down = (r_state == PDEB) && (w_state_nxt == DOWN);

    // Hold-time counter: starts at the accepted press, runs while DOWN,
    // pauses during release debounce and saturates; one strobe per press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lcnt   <= '0;
            r_lfired <= 1'b0;
            r_long   <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_enter_down) begin
                r_lcnt <= '0;
            end else if (r_state == IDLE) begin
                r_lcnt   <= '0;
                r_lfired <= 1'b0;
            end else if ((r_state == DOWN) && (r_lcnt != LONG_LAST)) begin
                r_lcnt <= r_lcnt + LONG_W'(1);
            end
            if (((r_state == DOWN) || (r_state == RDEB)) &&
                (r_lcnt == LONG_LAST) && !r_lfired) begin
                r_long   <= 1'b1;
                r_lfired <= 1'b1;
            end
        end
    end

    assign bus.key_long = r_long;
`else
    assign bus.key_long = 1'b0;
`endif

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces one raw, active-low mechanical push-button and produces a clean level plus single-cycle press/release strobes. It sits directly upstream of the board's flip-flop and register examples. It supplies their `d` input or clock-enable from a physical key, so each press gives exactly one clean event instead of a burst of bounce edges. Clock is the 12 MHz board oscillator.

## Interface

Parameters:
- `CNT_MAX`, default 240000: debounce window in clk cycles (20 ms at 12 MHz); valid range is at least 2.
- `CNT_W`, default 18: counter width; must satisfy 2^CNT_W > CNT_MAX.
- `LONG_MAX`, default 12000000: long-press threshold in clk cycles (1 s). Used only with `KEY_LONGPRESS_EN`.
- `LONG_W`, default 24: long-press counter width; must satisfy 2^LONG_W > LONG_MAX.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `key_n` in 1: raw key, asynchronous, 0 = pressed.
- `key_level` out 1: debounced state, 1 = pressed.
- `key_press` out 1: one-cycle pulse on an accepted press.
- `key_release` out 1: one-cycle pulse on an accepted release.
- `key_long` out 1: one-cycle pulse on a long press. Constant 0 when the macro is absent.

## Operation

- **Synchronizer.** `key_n` passes through a 2-FF synchronizer (`s1`, `s2`). Both flops reset to 1 (released). The FSM uses only `s2`.
- **FSM states:** IDLE, PDEB, DOWN, RDEB. A single counter `cnt` is cleared on every state change.
  - IDLE: if `s2`=0, go to PDEB.
  - PDEB: if `s2`=1, return to IDLE with no output (bounce rejected). Otherwise `cnt`++. When `cnt`==CNT_MAX-1 and `s2`=0, go to DOWN, pulse `key_press`, set `key_level`=1.
  - DOWN: if `s2`=1, go to RDEB.
  - RDEB: if `s2`=0, return to DOWN with no output. Otherwise `cnt`++. When `cnt`==CNT_MAX-1 and `s2`=1, go to IDLE, pulse `key_release`, clear `key_level`.
- **Registered outputs.** All outputs are registered. Strobes are high for exactly one cycle. `key_press` and `key_release` can never be high in the same cycle.
- **Counter width.** `cnt` never exceeds CNT_MAX-1, so it cannot wrap.
- **Reset values.** On reset, all outputs are 0, state is IDLE, all counters are 0, and `s1`=`s2`=1. Reset in any state, including mid-debounce or while pressed, returns to IDLE silently; no release pulse is issued.
- **Key held through reset.** If the key is held while reset is deasserted, it is treated as a fresh press: `key_press` fires after the normal latency.

## Timing

- **Press latency.** Let E0 be the first edge at which `s1` samples `key_n`=0. Then `s2`=0 after E1, PDEB with `cnt`=0 after E2, and `key_press`=1 and `key_level`=1 after E0+CNT_MAX+2. `key_press` returns to 0 one edge later.
- **Release latency.** Symmetric to press latency: `key_release` rises and `key_level` falls after E0'+CNT_MAX+2, where E0' is the first edge at which `s1` samples `key_n`=1.
- **Bounce rejection.** Any opposite sample on `s2` during PDEB/RDEB restarts the window from IDLE/DOWN. Therefore only an input stable for ≥CNT_MAX consecutive `s2` samples is accepted.
- **Short glitches.** A glitch shorter than one clock cycle may be missed or seen by `s1`. Either way it is rejected by the debounce window.
- **Throughput.** The minimum spacing between a press pulse and the following release pulse is CNT_MAX+1 cycles.

## Configuration

- Macro: `KEY_LONGPRESS_EN`.
- **Defined.** A counter `lcnt` (LONG_W bits) and a flag `lfired` are added.
  - `lcnt` is cleared on the transition into DOWN from PDEB.
  - It increments in DOWN, holds in RDEB, and clears in IDLE.
  - When `lcnt`==LONG_MAX-1 and `lfired`=0, `key_long` pulses for one cycle and `lfired` is set. This gives at most one `key_long` per press.
  - `lcnt` saturates at LONG_MAX-1. `lfired` clears in IDLE.
  - `key_long` therefore fires LONG_MAX cycles after `key_press` if the key is held throughout; any RDEB time adds to this delay.
- **Undefined.** `lcnt` and `lfired` are not instantiated and `key_long` is tied to 0.

## Test plan

Benches run with CNT_MAX=8 and LONG_MAX=32.

- **Reset.** Reset for 3 cycles with `key_n`=1 → all outputs 0; no pulse for 50 idle cycles.
- **Clean press.** `key_n` driven to 0 and first sampled at edge E0, held → `key_press` high in exactly the cycle after E0+10, `key_level`=1. Release clean → `key_release` pulse after E0'+10, `key_level`=0.
- **Bounce.** `key_n` toggles every 3 cycles for 40 cycles, then settles low → exactly one `key_press`, occurring 10 edges after the last falling sample; no `key_release` during the bounce.
- **Mid-press reset.** Reset asserted while in DOWN with `key_n`=0 → outputs 0 and no `key_release`. After reset is deasserted with the key still held, `key_press` fires 10 edges later.
- **Long press (macro defined).** Hold for 100 cycles → exactly one `key_long`, 32 cycles after `key_press`, then one `key_release` on release.
- **Long press (macro undefined).** Same stimulus → `key_long` stays 0 throughout.
